// File: rtl/graying_pkg.sv
// Shared types and constants for the RGB-to-gray pipeline.
package graying_pkg;

    typedef enum logic [1:0] {
        GRAY_BT601 = 2'd0,
        GRAY_BT709 = 2'd1,
        GRAY_AVG   = 2'd2,
        GRAY_USER  = 2'd3
    } gray_mode_e;

    // Reference weights, all expressed as Q0.16.
    localparam int          Q16_FRAC   = 16;
    localparam logic [17:0] Q16_601_R  = 18'd19595;
    localparam logic [17:0] Q16_601_G  = 18'd38470;
    localparam logic [17:0] Q16_601_B  = 18'd7471;
    localparam logic [17:0] Q16_709_R  = 18'd13933;
    localparam logic [17:0] Q16_709_G  = 18'd46871;
    localparam logic [17:0] Q16_709_B  = 18'd4732;
    localparam logic [17:0] Q16_AVG    = 18'd21845;

    // Rescale a Q0.16 weight to Q0.frac by dropping low fraction bits.
    function automatic logic [17:0] scale_q16(input logic [17:0] q16, input int frac);
        logic [17:0] res;
        res = q16 >> (Q16_FRAC - frac);
        return res;
    endfunction

endpackage

// File: rtl/graying_lane.sv
// One lane of the gray datapath: products in S2, sum/round/saturate in S3.
module graying_lane
    import graying_pkg::*;
#(
    parameter int COLOR_WIDTH = 8,
    parameter int COEF_FRAC   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en2,
    input  logic                     en3,
    input  logic [3*COLOR_WIDTH-1:0] pix,
    input  logic [COEF_FRAC+1:0]     coef_r,
    input  logic [COEF_FRAC+1:0]     coef_g,
    input  logic [COEF_FRAC+1:0]     coef_b,
    output logic [COLOR_WIDTH-1:0]   gray,
    output logic                     sat
);

    localparam int PROD_W = COLOR_WIDTH + COEF_FRAC + 2;
    localparam int ACC_W  = COLOR_WIDTH + COEF_FRAC + 4;
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);

    logic [COLOR_WIDTH-1:0] r_s, g_s, b_s;
    logic [PROD_W-1:0]      pr_r, pg_r, pb_r;
    logic [ACC_W-1:0]       acc_s;
    logic [ACC_W-1:0]       y_s;
    logic                   sat_s;
    logic [COLOR_WIDTH-1:0] gray_s;

    assign r_s = pix[2*COLOR_WIDTH +: COLOR_WIDTH];
    assign g_s = pix[COLOR_WIDTH   +: COLOR_WIDTH];
    assign b_s = pix[0             +: COLOR_WIDTH];

    // S2: full-width products, no truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_r <= '0;
            pg_r <= '0;
            pb_r <= '0;
        end else if (clr) begin
            pr_r <= '0;
            pg_r <= '0;
            pb_r <= '0;
        end else if (en2) begin
            pr_r <= PROD_W'(r_s) * PROD_W'(coef_r);
            pg_r <= PROD_W'(g_s) * PROD_W'(coef_g);
            pb_r <= PROD_W'(b_s) * PROD_W'(coef_b);
        end
    end

    // S3 combinational: sum, round to nearest, clip to the output range.
    always_comb begin
        acc_s  = ACC_W'(pr_r) + ACC_W'(pg_r) + ACC_W'(pb_r) + RND;
        y_s    = acc_s >> COEF_FRAC;
        sat_s  = |y_s[ACC_W-1:COLOR_WIDTH];
        if (sat_s) begin
            gray_s = {COLOR_WIDTH{1'b1}};
        end else begin
            gray_s = y_s[COLOR_WIDTH-1:0];
        end
    end

    // S3 register: gray and clip flag for the beat held at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray <= '0;
            sat  <= 1'b0;
        end else if (clr) begin
            gray <= '0;
            sat  <= 1'b0;
        end else if (en3) begin
            gray <= gray_s;
            sat  <= sat_s;
        end
    end

endmodule

// File: rtl/graying_pipe.sv
// Multi-lane RGB-to-gray converter, 3-stage elastic valid/ready pipeline.
module graying_pipe
    import graying_pkg::*;
#(
    parameter int COLOR_WIDTH = 8,
    parameter int LANES       = 1,
    parameter int COEF_FRAC   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [1:0]                     mode,
    input  logic [COEF_FRAC+1:0]           coef_r,
    input  logic [COEF_FRAC+1:0]           coef_g,
    input  logic [COEF_FRAC+1:0]           coef_b,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*3*COLOR_WIDTH-1:0] in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*COLOR_WIDTH-1:0]   out_data,
    output logic                           out_last,
    output logic [15:0]                    sat_count
);

    localparam int CFW   = COEF_FRAC + 2;
    localparam int PIX_W = 3 * COLOR_WIDTH;

    localparam logic [CFW-1:0] K601_R = CFW'(scale_q16(Q16_601_R, COEF_FRAC));
    localparam logic [CFW-1:0] K601_G = CFW'(scale_q16(Q16_601_G, COEF_FRAC));
    localparam logic [CFW-1:0] K601_B = CFW'(scale_q16(Q16_601_B, COEF_FRAC));
    localparam logic [CFW-1:0] K709_R = CFW'(scale_q16(Q16_709_R, COEF_FRAC));
    localparam logic [CFW-1:0] K709_G = CFW'(scale_q16(Q16_709_G, COEF_FRAC));
    localparam logic [CFW-1:0] K709_B = CFW'(scale_q16(Q16_709_B, COEF_FRAC));
    localparam logic [CFW-1:0] KAVG   = CFW'(scale_q16(Q16_AVG,   COEF_FRAC));

    gray_mode_e                  mode_s;
    logic                        s1_v_r, s2_v_r, s3_v_r;
    logic                        s1_last_r, s2_last_r, s3_last_r;
    logic                        ld1_s, ld2_s, ld3_s;
    logic                        en2_s, en3_s;
    logic [LANES*PIX_W-1:0]      s1_pix_r;
    logic [CFW-1:0]              s1_cr_r, s1_cg_r, s1_cb_r;
    logic [CFW-1:0]              sel_cr_s, sel_cg_s, sel_cb_s;
    logic [LANES*COLOR_WIDTH-1:0] gray_s;
    logic [LANES-1:0]            sat_s;
    logic [16:0]                 sat_sum_s;
    logic [15:0]                 sat_next_s;
    logic [15:0]                 sat_count_r;

    assign mode_s = gray_mode_e'(mode);

    // Ready chain: a stage may load when it is empty or its beat moves on.
    always_comb begin
        ld3_s    = !s3_v_r || out_ready;
        ld2_s    = !s2_v_r || ld3_s;
        ld1_s    = !s1_v_r || ld2_s;
        en2_s    = ld2_s && s1_v_r;
        en3_s    = ld3_s && s2_v_r;
        in_ready = flush || ld1_s;
    end

    // Coefficient selection for the beat being offered at the input.
    always_comb begin
        sel_cr_s = coef_r;
        sel_cg_s = coef_g;
        sel_cb_s = coef_b;
        case (mode_s)
            GRAY_BT601: begin
                sel_cr_s = K601_R;
                sel_cg_s = K601_G;
                sel_cb_s = K601_B;
            end
            GRAY_BT709: begin
                sel_cr_s = K709_R;
                sel_cg_s = K709_G;
                sel_cb_s = K709_B;
            end
            GRAY_AVG: begin
                sel_cr_s = KAVG;
                sel_cg_s = KAVG;
                sel_cb_s = KAVG;
            end
            default: begin
                sel_cr_s = coef_r;
                sel_cg_s = coef_g;
                sel_cb_s = coef_b;
            end
        endcase
    end

    // Stage valid bits; flush empties the whole pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            s3_v_r <= 1'b0;
        end else if (flush) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            s3_v_r <= 1'b0;
        end else begin
            if (ld1_s) s1_v_r <= in_valid;
            if (ld2_s) s2_v_r <= s1_v_r;
            if (ld3_s) s3_v_r <= s2_v_r;
        end
    end

    // S1 capture: pixels plus the coefficients in force when the beat arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pix_r  <= '0;
            s1_cr_r   <= '0;
            s1_cg_r   <= '0;
            s1_cb_r   <= '0;
            s1_last_r <= 1'b0;
        end else if (ld1_s && in_valid && !flush) begin
            s1_pix_r  <= in_data;
            s1_cr_r   <= sel_cr_s;
            s1_cg_r   <= sel_cg_s;
            s1_cb_r   <= sel_cb_s;
            s1_last_r <= in_last;
        end
    end

    // End-of-line flag travelling alongside the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_last_r <= 1'b0;
            s3_last_r <= 1'b0;
        end else if (flush) begin
            s2_last_r <= 1'b0;
            s3_last_r <= 1'b0;
        end else begin
            if (en2_s) s2_last_r <= s1_last_r;
            if (en3_s) s3_last_r <= s2_last_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        graying_lane #(
            .COLOR_WIDTH (COLOR_WIDTH),
            .COEF_FRAC   (COEF_FRAC)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (flush),
            .en2    (en2_s),
            .en3    (en3_s),
            .pix    (s1_pix_r[i*PIX_W +: PIX_W]),
            .coef_r (s1_cr_r),
            .coef_g (s1_cg_r),
            .coef_b (s1_cb_r),
            .gray   (gray_s[i*COLOR_WIDTH +: COLOR_WIDTH]),
            .sat    (sat_s[i])
        );
    end

    // Clip counter update: add clipped lanes only on an output transfer.
    always_comb begin
        sat_sum_s  = {1'b0, sat_count_r};
        sat_next_s = sat_count_r;
        for (int i = 0; i < LANES; i++) begin
            sat_sum_s = sat_sum_s + {16'd0, sat_s[i]};
        end
        if (s3_v_r && out_ready) begin
            if (sat_sum_s[16]) begin
                sat_next_s = 16'hFFFF;
            end else begin
                sat_next_s = sat_sum_s[15:0];
            end
        end else begin
            sat_next_s = sat_count_r;
        end
    end

    // Clip counter register; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= 16'd0;
        end else begin
            sat_count_r <= sat_next_s;
        end
    end

    assign out_valid = s3_v_r;
    assign out_data  = gray_s;
    assign out_last  = s3_last_r;
    assign sat_count = sat_count_r;

endmodule

// File: tb/tb_graying_pipe.sv
// Directed bench for graying_pipe: one single-lane and one four-lane instance.
module tb_graying_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic [1:0]  mode;
    logic [17:0] coef_r, coef_g, coef_b;
    logic        in_valid, in_ready, in_last;
    logic [23:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  out_data;
    logic [15:0] sat_count;

    logic [1:0]  mode4;
    logic [17:0] coef4;
    logic        in_valid4, in_ready4, in_last4;
    logic [95:0] in_data4;
    logic        out_valid4, out_ready4, out_last4;
    logic [31:0] out_data4;
    logic [15:0] sat_count4;

    int checks = 0;
    int errors = 0;

    graying_pipe #(.COLOR_WIDTH(8), .LANES(1), .COEF_FRAC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
        .coef_r(coef_r), .coef_g(coef_g), .coef_b(coef_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_count(sat_count)
    );

    graying_pipe #(.COLOR_WIDTH(8), .LANES(4), .COEF_FRAC(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode4),
        .coef_r(coef4), .coef_g(coef4), .coef_b(coef4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_last(out_last4), .sat_count(sat_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Send one beat into an empty single-lane pipe with out_ready held high.
    task automatic run_beat(input string tag, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [1:0] md, input logic lst,
                            input logic [7:0] expg);
        mode     = md;
        in_data  = {r, g, b};
        in_last  = lst;
        in_valid = 1'b1;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, ".early1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".early2"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"}, {24'd0, out_data}, {24'd0, expg});
        chk({tag, ".last"}, {31'd0, out_last}, {31'd0, lst});
        @(negedge clk);
        chk({tag, ".gone"}, {31'd0, out_valid}, 32'd0);
    endtask

    int         sent, got;
    logic [7:0] v, prev_d;
    logic       prev_l, prev_stall;
    logic [7:0] exp_q[$];
    logic       exp_l_q[$];

    initial begin
        rst_n = 1'b0; flush = 1'b0; mode = 2'd0;
        coef_r = 18'd0; coef_g = 18'd0; coef_b = 18'd0;
        in_valid = 1'b0; in_data = 24'd0; in_last = 1'b0; out_ready = 1'b1;
        mode4 = 2'd0; coef4 = 18'd0; in_valid4 = 1'b0; in_data4 = 96'd0;
        in_last4 = 1'b0; out_ready4 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_data", {24'd0, out_data}, 32'd0);
        chk("rst.out_last", {31'd0, out_last}, 32'd0);
        chk("rst.sat_count", {16'd0, sat_count}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // BT.601 primaries and white, latency 3
        run_beat("bt601_red",   8'd255, 8'd0,   8'd0,   2'd0, 1'b0, 8'd76);
        run_beat("bt601_green", 8'd0,   8'd255, 8'd0,   2'd0, 1'b1, 8'd150);
        run_beat("bt601_blue",  8'd0,   8'd0,   8'd255, 2'd0, 1'b0, 8'd29);
        run_beat("bt601_white", 8'd255, 8'd255, 8'd255, 2'd0, 1'b1, 8'd255);
        run_beat("avg",         8'd30,  8'd60,  8'd90,  2'd2, 1'b0, 8'd60);
        run_beat("bt709_white", 8'd255, 8'd255, 8'd255, 2'd1, 1'b0, 8'd255);
        chk("bt709.sat_count", {16'd0, sat_count}, 32'd0);

        // User coefficients saturate; counted at transfer, not while stalled
        coef_r = 18'd65535; coef_g = 18'd65535; coef_b = 18'd65535;
        mode = 2'd3; in_data = 24'hFFFFFF; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        mode = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("user.valid", {31'd0, out_valid}, 32'd1);
        chk("user.data", {24'd0, out_data}, 32'd255);
        chk("user.stall_cnt", {16'd0, sat_count}, 32'd0);
        @(negedge clk);
        chk("user.stall_valid", {31'd0, out_valid}, 32'd1);
        chk("user.stall_cnt2", {16'd0, sat_count}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("user.sat_count", {16'd0, sat_count}, 32'd1);
        chk("user.gone", {31'd0, out_valid}, 32'd0);

        // Four lanes: BT.601 mixed, then saturating white
        mode4 = 2'd0;
        in_data4 = {24'h1E3C5A, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("l4.valid", {31'd0, out_valid4}, 32'd1);
        chk("l4.data", out_data4, 32'h361D964C);
        @(negedge clk);
        chk("l4.sat0", {16'd0, sat_count4}, 32'd0);
        mode4 = 2'd3; coef4 = 18'd65535;
        in_data4 = {12{8'hFF}};
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("l4w.data", out_data4, 32'hFFFFFFFF);
        @(negedge clk);
        chk("l4w.sat_count", {16'd0, sat_count4}, 32'd4);

        // Backpressure: gray pixels in average mode map to themselves
        mode = 2'd2;
        sent = 0; got = 0; prev_stall = 1'b0; prev_d = 8'd0; prev_l = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            v         = 8'(sent * 11 + 3);
            in_data   = {v, v, v};
            in_last   = (sent % 5 == 4);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk("bp.stable_valid", {31'd0, out_valid}, 32'd1);
                chk("bp.stable_data", {24'd0, out_data}, {24'd0, prev_d});
                chk("bp.stable_last", {31'd0, out_last}, {31'd0, prev_l});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(v);
                exp_l_q.push_back(in_last);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp.spurious", 32'd1, 32'd0);
                end else begin
                    chk("bp.data", {24'd0, out_data}, {24'd0, exp_q[0]});
                    chk("bp.last", {31'd0, out_last}, {31'd0, exp_l_q[0]});
                    void'(exp_q.pop_front());
                    void'(exp_l_q.pop_front());
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        chk("bp.count", got, 32'd20);
        @(negedge clk);
        @(negedge clk);
        chk("bp.drained", {31'd0, out_valid}, 32'd0);

        // Flush with three beats in flight
        mode = 2'd0;
        in_data = 24'hFF0000; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_data = 24'h00FF00; in_last = 1'b0;
        @(negedge clk);
        in_data = 24'h0000FF;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fl.pre_valid", {31'd0, out_valid}, 32'd1);
        chk("fl.pre_data", {24'd0, out_data}, 32'd76);
        chk("fl.pre_last", {31'd0, out_last}, 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_data = 24'hFFFFFF;
        #1;
        chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl.valid", {31'd0, out_valid}, 32'd0);
        chk("fl.data", {24'd0, out_data}, 32'd0);
        chk("fl.last", {31'd0, out_last}, 32'd0);
        chk("fl.sat_kept", {16'd0, sat_count}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl.empty", {31'd0, out_valid}, 32'd0);
        end
        run_beat("post_flush", 8'd0, 8'd0, 8'd255, 2'd0, 1'b0, 8'd29);
        chk("post_flush.sat", {16'd0, sat_count}, 32'd1);

        // Reset mid-stream
        in_data = 24'hFF0000; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr.pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr.valid", {31'd0, out_valid}, 32'd0);
        chk("mr.sat_count", {16'd0, sat_count}, 32'd0);
        chk("mr.sat_count4", {16'd0, sat_count4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        run_beat("post_reset", 8'd0, 8'd255, 8'd0, 2'd0, 1'b1, 8'd150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
